issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_issue_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Out-of-order issue queue: multi-lane dispatch, CDB wakeup, age-ordered
// select per issue port, and squash of entries younger than a given ROB index.
// Optional build macro IQ_WAKEUP_BYPASS_EN: a wakeup seen this cycle counts
// toward eligibility this cycle; without it only registered ready bits count.
module issue_queue #(
    parameter int unsigned SIZE      = 16,
    parameter int unsigned DISP_W    = 2,
    parameter int unsigned ISSUE_W   = 3,
    parameter int unsigned CDB_W     = 3,
    parameter int unsigned PHY_W     = 6,
    parameter int unsigned ROB_W     = 5,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned CLASS_N   = 3,
    parameter logic [ISSUE_W*CLASS_N-1:0] PORT_CLASS = 9'b100_010_001
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DISP_W-1:0]              disp_valid,
    output logic                           disp_ready,
    input  logic [DISP_W*CLASS_N-1:0]      disp_class,
    input  logic [DISP_W*2*PHY_W-1:0]      disp_src,
    input  logic [DISP_W*2-1:0]            disp_src_rdy,
    input  logic [DISP_W*PHY_W-1:0]        disp_dst,
    input  logic [DISP_W*ROB_W-1:0]        disp_rob_idx,
    input  logic [DISP_W*PAYLOAD_W-1:0]    disp_payload,
    input  logic [CDB_W-1:0]               wk_valid,
    input  logic [CDB_W*PHY_W-1:0]         wk_tag,
    input  logic [ISSUE_W-1:0]             iss_avail,
    output logic [ISSUE_W-1:0]             iss_valid,
    output logic [ISSUE_W*2*PHY_W-1:0]     iss_src,
    output logic [ISSUE_W*PHY_W-1:0]       iss_dst,
    output logic [ISSUE_W*ROB_W-1:0]       iss_rob_idx,
    output logic [ISSUE_W*PAYLOAD_W-1:0]   iss_payload,
    input  logic [ROB_W-1:0]               rob_head,
    input  logic                           sq_valid,
    input  logic [ROB_W-1:0]               sq_rob_idx,
    output logic [$clog2(SIZE+1)-1:0]      count
);

    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(SIZE + 1);

    // Entry storage
    logic [SIZE-1:0]       r_valid;
    logic [CLASS_N-1:0]    r_class   [SIZE];
    logic [PHY_W-1:0]      r_src     [SIZE][2];
    logic [1:0]            r_rdy     [SIZE];
    logic [PHY_W-1:0]      r_dst     [SIZE];
    logic [ROB_W-1:0]      r_rob     [SIZE];
    logic [PAYLOAD_W-1:0]  r_payload [SIZE];
    logic [CNT_W-1:0]      r_count;

    // Combinational helpers
    logic [1:0]            w_wk_hit      [SIZE];
    logic [1:0]            w_disp_wk_hit [DISP_W];
    logic [ROB_W-1:0]      w_age         [SIZE];
    logic [ROB_W-1:0]      w_sq_age;
    logic [SIZE-1:0]       w_kill;
    logic [SIZE-1:0]       w_src_ready;
    logic [SIZE-1:0]       w_taken;
    logic [ISSUE_W-1:0]    w_sel_valid;
    logic [IDX_W-1:0]      w_sel_idx     [ISSUE_W];
    logic [ROB_W-1:0]      w_best_age;
    logic                  w_sel_found;
    logic [DISP_W-1:0]     w_disp_fire;
    logic [IDX_W-1:0]      w_alloc_idx   [DISP_W];
    logic [SIZE-1:0]       w_alloc_used;
    logic                  w_alloc_found;
    logic [CNT_W-1:0]      w_n_disp;
    logic [CNT_W-1:0]      w_n_iss;
    logic [CNT_W-1:0]      w_n_kill;
    logic [CNT_W-1:0]      w_count_nxt;

    assign count = r_count;

    // Tag match of every wakeup channel against stored and dispatching sources
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            w_wk_hit[i] = 2'b00;
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < CDB_W; c++)
                    if (wk_valid[c] && (wk_tag[c*PHY_W +: PHY_W] == r_src[i][s]))
                        w_wk_hit[i][s] = 1'b1;
        end
        for (int l = 0; l < DISP_W; l++) begin
            w_disp_wk_hit[l] = 2'b00;
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < CDB_W; c++)
                    if (wk_valid[c] &&
                        (wk_tag[c*PHY_W +: PHY_W] == disp_src[(l*2+s)*PHY_W +: PHY_W]))
                        w_disp_wk_hit[l][s] = 1'b1;
        end
    end

    // Relative age vs. ROB head, squash kill mask and operand readiness
    always_comb begin
        w_sq_age = sq_rob_idx - rob_head;
        for (int i = 0; i < SIZE; i++) begin
            w_age[i]  = r_rob[i] - rob_head;
            w_kill[i] = sq_valid && r_valid[i] && (w_age[i] > w_sq_age);
`ifdef IQ_WAKEUP_BYPASS_EN
            w_src_ready[i] = &(r_rdy[i] | w_wk_hit[i]);
`else
            w_src_ready[i] = &r_rdy[i];
`endif
        end
    end

    // Oldest-first select, ports in ascending order so lower ports win ties
    always_comb begin
        w_taken    = '0;
        w_best_age = '0;
        w_sel_found = 1'b0;
        for (int p = 0; p < ISSUE_W; p++) begin
            w_sel_found  = 1'b0;
            w_best_age   = '0;
            w_sel_idx[p] = '0;
            for (int i = 0; i < SIZE; i++) begin
                if (!reset && iss_avail[p] && r_valid[i] && w_src_ready[i] &&
                    !w_kill[i] && !w_taken[i] &&
                    (|(r_class[i] & PORT_CLASS[p*CLASS_N +: CLASS_N])) &&
                    (!w_sel_found || (w_age[i] < w_best_age))) begin
                    w_sel_found  = 1'b1;
                    w_best_age   = w_age[i];
                    w_sel_idx[p] = IDX_W'(i);
                end
            end
            w_sel_valid[p] = w_sel_found;
            if (w_sel_found)
                w_taken[w_sel_idx[p]] = 1'b1;
        end
    end

    // Issue port outputs, zero on idle ports
    always_comb begin
        iss_valid   = w_sel_valid;
        iss_src     = '0;
        iss_dst     = '0;
        iss_rob_idx = '0;
        iss_payload = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (w_sel_valid[p]) begin
                iss_src[(p*2)*PHY_W +: PHY_W]   = r_src[w_sel_idx[p]][0];
                iss_src[(p*2+1)*PHY_W +: PHY_W] = r_src[w_sel_idx[p]][1];
                iss_dst[p*PHY_W +: PHY_W]       = r_dst[w_sel_idx[p]];
                iss_rob_idx[p*ROB_W +: ROB_W]   = r_rob[w_sel_idx[p]];
                iss_payload[p*PAYLOAD_W +: PAYLOAD_W] = r_payload[w_sel_idx[p]];
            end
        end
    end

    // Dispatch acceptance and lowest-free-entry allocation in lane order
    always_comb begin
        disp_ready    = reset || (r_count <= CNT_W'(SIZE - DISP_W));
        w_alloc_used  = '0;
        w_alloc_found = 1'b0;
        for (int l = 0; l < DISP_W; l++) begin
            w_alloc_found  = 1'b0;
            w_alloc_idx[l] = '0;
            if (disp_valid[l] && disp_ready && !sq_valid && !reset) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (!w_alloc_found && !r_valid[i] && !w_alloc_used[i]) begin
                        w_alloc_found  = 1'b1;
                        w_alloc_idx[l] = IDX_W'(i);
                    end
                end
            end
            w_disp_fire[l] = w_alloc_found;
            if (w_alloc_found)
                w_alloc_used[w_alloc_idx[l]] = 1'b1;
        end
    end

    // Next occupancy: arrivals minus issues minus squashed entries
    always_comb begin
        w_n_disp = '0;
        w_n_iss  = '0;
        w_n_kill = '0;
        for (int l = 0; l < DISP_W; l++)
            if (w_disp_fire[l]) w_n_disp = w_n_disp + CNT_W'(1);
        for (int i = 0; i < SIZE; i++) begin
            if (w_taken[i]) w_n_iss  = w_n_iss  + CNT_W'(1);
            if (w_kill[i])  w_n_kill = w_n_kill + CNT_W'(1);
        end
        w_count_nxt = r_count + w_n_disp - w_n_iss - w_n_kill;
    end

    // Valid bits and occupancy counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < SIZE; i++)
                if (w_taken[i] || w_kill[i])
                    r_valid[i] <= 1'b0;
            for (int l = 0; l < DISP_W; l++)
                if (w_disp_fire[l])
                    r_valid[w_alloc_idx[l]] <= 1'b1;
        end
    end

    // Entry payload: wakeup sets ready bits, dispatch overwrites allocated entries
    always_ff @(posedge clock) begin
        for (int i = 0; i < SIZE; i++)
            r_rdy[i] <= r_rdy[i] | w_wk_hit[i];
        for (int l = 0; l < DISP_W; l++) begin
            if (w_disp_fire[l]) begin
                r_class[w_alloc_idx[l]]   <= disp_class[l*CLASS_N +: CLASS_N];
                r_src[w_alloc_idx[l]][0]  <= disp_src[(l*2)*PHY_W +: PHY_W];
                r_src[w_alloc_idx[l]][1]  <= disp_src[(l*2+1)*PHY_W +: PHY_W];
                r_rdy[w_alloc_idx[l]]     <= disp_src_rdy[l*2 +: 2] | w_disp_wk_hit[l];
                r_dst[w_alloc_idx[l]]     <= disp_dst[l*PHY_W +: PHY_W];
                r_rob[w_alloc_idx[l]]     <= disp_rob_idx[l*ROB_W +: ROB_W];
                r_payload[w_alloc_idx[l]] <= disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue; expected issues go to a scoreboard
// queue and are popped by a monitor whenever a port reports a valid issue.
module tb_issue_queue;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    disp_valid;
    logic          disp_ready;
    logic [5:0]    disp_class;
    logic [23:0]   disp_src;
    logic [3:0]    disp_src_rdy;
    logic [11:0]   disp_dst;
    logic [9:0]    disp_rob_idx;
    logic [127:0]  disp_payload;
    logic [2:0]    wk_valid;
    logic [17:0]   wk_tag;
    logic [2:0]    iss_avail;
    logic [2:0]    iss_valid;
    logic [35:0]   iss_src;
    logic [17:0]   iss_dst;
    logic [14:0]   iss_rob_idx;
    logic [191:0]  iss_payload;
    logic [4:0]    rob_head;
    logic          sq_valid;
    logic [4:0]    sq_rob_idx;
    logic [4:0]    count;

    issue_queue dut (
        .clock        (clock),
        .reset        (reset),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_class   (disp_class),
        .disp_src     (disp_src),
        .disp_src_rdy (disp_src_rdy),
        .disp_dst     (disp_dst),
        .disp_rob_idx (disp_rob_idx),
        .disp_payload (disp_payload),
        .wk_valid     (wk_valid),
        .wk_tag       (wk_tag),
        .iss_avail    (iss_avail),
        .iss_valid    (iss_valid),
        .iss_src      (iss_src),
        .iss_dst      (iss_dst),
        .iss_rob_idx  (iss_rob_idx),
        .iss_payload  (iss_payload),
        .rob_head     (rob_head),
        .sq_valid     (sq_valid),
        .sq_rob_idx   (sq_rob_idx),
        .count        (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         port;
        logic [4:0] rob;
        logic [5:0] dst;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Count one comparison and report it when the values differ
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_iss(input int p, input logic [4:0] rob);
        exp_t e;
        e.port = p;
        e.rob  = rob;
        e.dst  = 6'(rob) + 6'd32;
        exp_q.push_back(e);
    endtask

    // Drive one dispatch lane; source 1 is always ready with an unused tag
    task automatic lane(input int l, input logic [2:0] cls, input logic [5:0] t0,
                        input logic r0, input logic [4:0] rob);
        disp_valid[l]               = 1'b1;
        disp_class[l*3 +: 3]        = cls;
        disp_src[(l*2)*6 +: 6]      = t0;
        disp_src[(l*2+1)*6 +: 6]    = 6'd63;
        disp_src_rdy[l*2]           = r0;
        disp_src_rdy[l*2+1]         = 1'b1;
        disp_dst[l*6 +: 6]          = 6'(rob) + 6'd32;
        disp_rob_idx[l*5 +: 5]      = rob;
        disp_payload[l*64 +: 64]    = {32'hC0DE0000, 27'd0, rob};
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        disp_valid = '0;
        wk_valid   = '0;
        wk_tag     = '0;
        sq_valid   = 1'b0;
    endtask

    // Scoreboard monitor: every valid issue must match the next expected one
    always @(negedge clock) begin
        if (!reset) begin
            for (int p = 0; p < 3; p++) begin
                if (iss_valid[p]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("spurious_issue_p%0d_rob", p), 64'(iss_rob_idx[p*5 +: 5]), 64'hFFFF);
                    end else begin
                        e_mon = exp_q.pop_front();
                        chk("iss_port", 64'(p), 64'(e_mon.port));
                        chk("iss_rob", 64'(iss_rob_idx[p*5 +: 5]), 64'(e_mon.rob));
                        chk("iss_dst", 64'(iss_dst[p*6 +: 6]), 64'(e_mon.dst));
                        chk("iss_payload", iss_payload[p*64 +: 64], {32'hC0DE0000, 27'd0, e_mon.rob});
                    end
                end else begin
                    chk("idle_port_zero", 64'(iss_rob_idx[p*5 +: 5]), 64'd0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        disp_valid = '0; disp_class = '0; disp_src = '0; disp_src_rdy = '0;
        disp_dst = '0; disp_rob_idx = '0; disp_payload = '0;
        wk_valid = '0; wk_tag = '0; iss_avail = '0; rob_head = '0;
        sq_valid = 1'b0; sq_rob_idx = '0;

        // Reset behaviour, and reset overriding dispatch/wakeup/squash
        @(posedge clock); #1;
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        lane(0, 3'b001, 6'd0, 1'b1, 5'd7);
        iss_avail = 3'b111; wk_valid = 3'b001; sq_valid = 1'b1;
        #1;
        chk("rst_iss_valid_busy", 64'(iss_valid), 64'd0);
        chk("rst_disp_ready_busy", 64'(disp_ready), 64'd1);
        tick();
        chk("rst_count", 64'(count), 64'd0);
        reset = 1'b0; iss_avail = '0;
        tick();
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("post_rst_iss_valid", 64'(iss_valid), 64'd0);

        // Two ALU ops, rob 3 and 1: rob 1 issues first, one per cycle
        iss_avail = 3'b111;
        lane(0, 3'b001, 6'd0, 1'b1, 5'd3);
        lane(1, 3'b001, 6'd0, 1'b1, 5'd1);
        #1 chk("t1_dispatch_cycle_no_issue", 64'(iss_valid), 64'd0);
        tick();
        expect_iss(0, 5'd1);
        #1 chk("t1_count2", 64'(count), 64'd2);
        chk("t1_iss_mask", 64'(iss_valid), 64'b001);
        tick();
        expect_iss(0, 5'd3);
        #1 chk("t1_count1", 64'(count), 64'd1);
        tick();
        chk("t1_count0", 64'(count), 64'd0);
        iss_avail = '0;

        // Fill all 16 entries, then check the free-slot threshold
        for (int k = 0; k < 8; k++) begin
            lane(0, 3'b001, 6'd0, 1'b1, 5'(2*k));
            lane(1, 3'b001, 6'd0, 1'b1, 5'(2*k+1));
            tick();
        end
        chk("t2_full_count", 64'(count), 64'd16);
        chk("t2_full_ready", 64'(disp_ready), 64'd0);
        lane(0, 3'b001, 6'd0, 1'b1, 5'd20);
        tick();
        chk("t2_full_drop", 64'(count), 64'd16);
        iss_avail = 3'b001; expect_iss(0, 5'd0);
        tick(); iss_avail = '0;
        chk("t2_count15", 64'(count), 64'd15);
        chk("t2_ready_15free", 64'(disp_ready), 64'd0);
        iss_avail = 3'b001; expect_iss(0, 5'd1);
        tick(); iss_avail = '0;
        chk("t2_count14", 64'(count), 64'd14);
        chk("t2_ready_14", 64'(disp_ready), 64'd1);
        iss_avail = 3'b001;
        for (int k = 2; k < 16; k++) begin
            expect_iss(0, 5'(k));
            tick();
        end
        iss_avail = '0;
        chk("t2_drained", 64'(count), 64'd0);

        // Wakeup of tag 12 while the entry waits
        iss_avail = 3'b001;
        lane(0, 3'b001, 6'd12, 1'b0, 5'd4);
        tick();
        chk("t3_waiting", 64'(iss_valid), 64'd0);
        chk("t3_count", 64'(count), 64'd1);
        wk_valid = 3'b010; wk_tag[6 +: 6] = 6'd12;
`ifdef IQ_WAKEUP_BYPASS_EN
        expect_iss(0, 5'd4);
        #1 chk("t3_bypass_issue", 64'(iss_valid), 64'b001);
        tick();
`else
        #1 chk("t3_no_bypass", 64'(iss_valid), 64'd0);
        tick();
        expect_iss(0, 5'd4);
        #1 chk("t3_issue_next", 64'(iss_valid), 64'b001);
        tick();
`endif
        chk("t3_count0", 64'(count), 64'd0);
        iss_avail = '0;

        // Squash at rob 5 removes rob 9 and drops same-cycle dispatch
        lane(0, 3'b001, 6'd0, 1'b1, 5'd2);
        lane(1, 3'b001, 6'd0, 1'b1, 5'd5);
        tick();
        lane(0, 3'b100, 6'd0, 1'b1, 5'd9);
        tick();
        chk("t4_count3", 64'(count), 64'd3);
        sq_valid = 1'b1; sq_rob_idx = 5'd5; iss_avail = 3'b100;
        lane(0, 3'b001, 6'd0, 1'b1, 5'd10);
        #1 chk("t4_killed_no_issue", 64'(iss_valid), 64'd0);
        tick(); iss_avail = '0;
        chk("t4_count2", 64'(count), 64'd2);
        iss_avail = 3'b101;
        expect_iss(0, 5'd2);
        tick();
        expect_iss(0, 5'd5);
        tick();
        chk("t4_count0", 64'(count), 64'd0);
        tick();
        iss_avail = '0;

        // Dispatch-cycle wakeup of tag 7: issue exactly one cycle later
        iss_avail = 3'b001;
        lane(0, 3'b001, 6'd7, 1'b0, 5'd6);
        wk_valid = 3'b100; wk_tag[12 +: 6] = 6'd7;
        #1 chk("t5_same_cycle", 64'(iss_valid), 64'd0);
        tick();
        expect_iss(0, 5'd6);
        #1 chk("t5_next_cycle", 64'(iss_valid), 64'b001);
        tick();
        chk("t5_count0", 64'(count), 64'd0);
        iss_avail = '0;

        // Age wrap: head 30, rob 31 is older than rob 1
        rob_head = 5'd30;
        lane(0, 3'b001, 6'd0, 1'b1, 5'd1);
        lane(1, 3'b001, 6'd0, 1'b1, 5'd31);
        tick();
        iss_avail = 3'b001;
        expect_iss(0, 5'd31);
        tick();
        expect_iss(0, 5'd1);
        tick();
        iss_avail = '0;
        chk("t6_count0", 64'(count), 64'd0);

        // Three classes issue in parallel on their own ports
        rob_head = 5'd0;
        lane(0, 3'b010, 6'd0, 1'b1, 5'd8);
        lane(1, 3'b100, 6'd0, 1'b1, 5'd3);
        tick();
        lane(0, 3'b001, 6'd0, 1'b1, 5'd12);
        tick();
        iss_avail = 3'b111;
        expect_iss(0, 5'd12);
        expect_iss(1, 5'd8);
        expect_iss(2, 5'd3);
        #1 chk("t7_all_ports", 64'(iss_valid), 64'b111);
        tick();
        iss_avail = '0;
        chk("t7_count0", 64'(count), 64'd0);

        tick();
        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
